// File: rtl/risc_pkg.sv
// Shared fetch-stage types and constants: datapath width, NOP encoding, PC step,
// fetch FSM states and the {pc, inst} payload handed to decode.
package risc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: redirect from execute, ROM address/data, and the
// valid/ready channel to decode. master = fetch stage, slave = its environment.
interface inst_fetch_if;
  import risc_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer between the ROM response and decode.
// Only compiled when FETCH_SKID_EN is defined; the default build has no skid storage.
`ifdef FETCH_SKID_EN
module fetch_skid_buf
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready_c,
  input  fetch_pkt_t in_pkt,
  output logic       out_valid_c,
  input  logic       out_ready,
  output fetch_pkt_t out_pkt_c
);

  logic       full_q;
  fetch_pkt_t pkt_q;

  // Upstream may advance whenever the entry is empty or is leaving this cycle.
  assign in_ready_c  = !full_q || out_ready;
  assign out_valid_c = full_q || in_valid;
  assign out_pkt_c   = full_q ? pkt_q : in_pkt;

  // Capture on a refused response, refill or drain on acceptance, drop on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      pkt_q  <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (full_q) begin
      if (out_ready) begin
        full_q <= in_valid;
        pkt_q  <= in_pkt;
      end
    end else if (in_valid && !out_ready) begin
      full_q <= 1'b1;
      pkt_q  <= in_pkt;
    end
  end

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the 1-cycle-latency ROM, pairs
// returning data with its PC and presents {pc, inst} to decode.
// Build option FETCH_SKID_EN: absorb decode back-pressure in a 1-entry skid
// buffer instead of replaying the held address (removes out_ready -> imem_addr).
module inst_fetch
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] imem_addr_c;
  logic            sink_ready_c;

`ifdef FETCH_SKID_EN
  fetch_pkt_t resp_pkt_c;
  fetch_pkt_t out_pkt_c;
  logic       skid_out_valid_c;

  assign resp_pkt_c = '{pc: resp_pc_q, inst: bus.imem_rdata};

  fetch_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (bus.redirect_valid),
    .in_valid    (resp_valid_q),
    .in_ready_c  (sink_ready_c),
    .in_pkt      (resp_pkt_c),
    .out_valid_c (skid_out_valid_c),
    .out_ready   (bus.out_ready),
    .out_pkt_c   (out_pkt_c)
  );

  assign bus.out_valid = skid_out_valid_c;
  assign bus.out_pc    = out_pkt_c.pc;
  assign bus.out_inst  = skid_out_valid_c ? out_pkt_c.inst : INST_NOP;
`else
  assign sink_ready_c  = bus.out_ready;
  assign bus.out_valid = resp_valid_q;
  assign bus.out_pc    = resp_pc_q;
  assign bus.out_inst  = resp_valid_q ? bus.imem_rdata : INST_NOP;
`endif

  assign bus.imem_addr = imem_addr_c;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_BOOT;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state, PC update and ROM address; a redirect overrides everything.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    imem_addr_c  = fetch_pc_q;

    case (state_q)
      FETCH_BOOT, FETCH_FLUSH: begin
        resp_pc_d    = fetch_pc_q;
        resp_valid_d = 1'b1;
        fetch_pc_d   = pc_next(fetch_pc_q);
        state_d      = FETCH_RUN;
      end
      FETCH_RUN: begin
`ifdef FETCH_SKID_EN
        // Skid full and not draining: drop the in-flight word and refetch it later.
        if (!sink_ready_c) begin
          fetch_pc_d   = resp_valid_q ? resp_pc_q : fetch_pc_q;
          resp_valid_d = 1'b0;
        end else begin
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          fetch_pc_d   = pc_next(fetch_pc_q);
        end
`else
        // Refused output: re-read the same word so ROM data stays stable.
        if (resp_valid_q && !sink_ready_c) begin
          imem_addr_c = resp_pc_q;
          state_d     = FETCH_HOLD;
        end else begin
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          fetch_pc_d   = pc_next(fetch_pc_q);
        end
`endif
      end
      FETCH_HOLD: begin
        imem_addr_c = resp_pc_q;
        if (bus.out_ready) begin
          resp_valid_d = 1'b0;
          state_d      = FETCH_RUN;
        end
      end
      default: state_d = FETCH_BOOT;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d   = bus.redirect_pc & PC_ALIGN_MASK;
      resp_valid_d = 1'b0;
      state_d      = FETCH_FLUSH;
    end
  end

endmodule
